// File: rtl/wfg_record_spi.sv
// -----------------------------------------------------------------------------
// wfg_record_spi
//
// SPI slave receiver: capture-side counterpart of the waveform generator's SPI
// driver. sclk / cs / sdi are oversampled on clk and deserialised into
// 8/16/24/32-bit words in any CPOL/CPHA mode, MSB- or LSB-first. Each word is
// emitted on an AXI-stream master port; the last word of a chip-select frame
// carries tlast.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   wfg_record_spi_sclk_i      SPI clock (asynchronous)
//   wfg_record_spi_cs_ni       chip select (asynchronous, polarity cfg_sspol_q_i)
//   wfg_record_spi_sdi_i       serial data in (asynchronous)
//   wfg_axis_tvalid_o/_tready_i/_tlast_o/_tdata_o
//                              AXIS master, tdata right-aligned, zero-extended
//   ctrl_en_q_i                receiver enable; low also clears sticky flags
//   cfg_cpha_q_i, cfg_cpol_q_i SPI mode
//   cfg_lsbfirst_q_i           1 = LSB received first
//   cfg_dff_q_i                word size: 0=8, 1=16, 2=24, 3=32 bits
//   cfg_sspol_q_i              0 = CS active low, 1 = CS active high
//   status_ovf_o               sticky: word dropped, output slice full
//   status_partial_o           sticky: CS ended mid-word
// -----------------------------------------------------------------------------
module wfg_record_spi #(
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wfg_record_spi_sclk_i,
    input  logic                       wfg_record_spi_cs_ni,
    input  logic                       wfg_record_spi_sdi_i,
    output logic                       wfg_axis_tvalid_o,
    input  logic                       wfg_axis_tready_i,
    output logic                       wfg_axis_tlast_o,
    output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
    input  logic                       ctrl_en_q_i,
    input  logic                       cfg_cpha_q_i,
    input  logic                       cfg_cpol_q_i,
    input  logic                       cfg_lsbfirst_q_i,
    input  logic [1:0]                 cfg_dff_q_i,
    input  logic                       cfg_sspol_q_i,
    output logic                       status_ovf_o,
    output logic                       status_partial_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and edge-detect stage. Preset to the idle pin levels
    // so that leaving reset does not look like a CS or sclk transition.
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
    logic       sclk_prev_q, cs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            sdi_sync_q  <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], wfg_record_spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[0], wfg_record_spi_cs_ni};
            sdi_sync_q  <= {sdi_sync_q[0], wfg_record_spi_sdi_i};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    // ------------------------------------------------------------------
    // Frame-latched configuration and datapath registers
    // ------------------------------------------------------------------
    state_t                     state_q, state_d;
    logic                       cpol_q, cpha_q, lsb_q, sspol_q;
    logic [1:0]                 dff_q;
    logic [4:0]                 bitcnt_q;
    logic [AXIS_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                       stg_vld_q;
    logic [AXIS_DATA_WIDTH-1:0] stg_data_q;
    logic                       tvalid_q, tlast_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic                       ovf_q, partial_q;

    // Polarity used to interpret CS: live config while idle, the value
    // latched at frame start afterwards. Both the current and previous
    // samples use the same polarity, so a config change never fakes an edge.
    logic sspol_eff, cs_act, cs_act_prev, cs_rise, cs_fall;
    logic sclk_s, sdi_s, lead_edge, trail_edge, sample_edge, last_bit;

    always_comb begin
        sspol_eff   = (state_q == ST_IDLE) ? cfg_sspol_q_i : sspol_q;
        cs_act      = cs_sync_q[1] ^ ~sspol_eff;
        cs_act_prev = cs_prev_q ^ ~sspol_eff;
        cs_rise     = cs_act & ~cs_act_prev;
        cs_fall     = ~cs_act & cs_act_prev;
        sclk_s      = sclk_sync_q[1];
        sdi_s       = sdi_sync_q[1];
        lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
        trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
        sample_edge = cpha_q ? trail_edge : lead_edge;
        // 8*(dff+1)-1 == dff*8 + 7
        last_bit    = (bitcnt_q == {dff_q, 3'b111});
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q_i && cs_rise) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!ctrl_en_q_i) begin
                    state_d = ST_IDLE;
                end else if (cs_fall) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: output (control strobe) logic
    logic start, abort, flush, shift_en, word_done;

    always_comb begin
        start     = 1'b0;
        abort     = 1'b0;
        flush     = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        case (state_q)
            ST_IDLE:  start = ctrl_en_q_i & cs_rise;
            ST_SHIFT: begin
                abort     = ~ctrl_en_q_i;
                shift_en  = ctrl_en_q_i & ~cs_fall & cs_act & sample_edge;
                word_done = ctrl_en_q_i & ~cs_fall & cs_act & sample_edge & last_bit;
            end
            ST_FLUSH: flush = 1'b1;
            default:  ;
        endcase
    end

    // Shift register next value for the current sample
    always_comb begin
        if (lsb_q) begin
            shreg_d = shreg_q | (AXIS_DATA_WIDTH'(sdi_s) << bitcnt_q);
        end else begin
            shreg_d = {shreg_q[AXIS_DATA_WIDTH-2:0], sdi_s};
        end
    end

    // The staged word leaves on the next completion (tlast=0) or at flush
    // (tlast=1); the output slice accepts it only if it is empty or draining.
    logic push, push_last, load, drop;

    always_comb begin
        push      = stg_vld_q & (word_done | flush);
        push_last = flush;
        load      = push & (~tvalid_q | wfg_axis_tready_i);
        drop      = push & tvalid_q & ~wfg_axis_tready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sspol_q    <= 1'b0;
            dff_q      <= 2'd0;
            bitcnt_q   <= 5'd0;
            shreg_q    <= '0;
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            ovf_q      <= 1'b0;
            partial_q  <= 1'b0;
        end else begin
            // Frame start: latch mode, clear the deserialiser
            if (start) begin
                cpol_q   <= cfg_cpol_q_i;
                cpha_q   <= cfg_cpha_q_i;
                lsb_q    <= cfg_lsbfirst_q_i;
                dff_q    <= cfg_dff_q_i;
                sspol_q  <= cfg_sspol_q_i;
                bitcnt_q <= 5'd0;
                shreg_q  <= '0;
            end else if (shift_en) begin
                // Clearing on completion keeps the next word zero-extended
                if (word_done) begin
                    bitcnt_q <= 5'd0;
                    shreg_q  <= '0;
                end else begin
                    bitcnt_q <= bitcnt_q + 5'd1;
                    shreg_q  <= shreg_d;
                end
            end

            // Staging register
            if (abort) begin
                stg_vld_q <= 1'b0;
            end else if (word_done) begin
                stg_vld_q  <= 1'b1;
                stg_data_q <= shreg_d;
            end else if (flush) begin
                stg_vld_q <= 1'b0;
            end

            // Output register slice
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= stg_data_q;
                tlast_q  <= push_last;
            end else if (tvalid_q && wfg_axis_tready_i) begin
                tvalid_q <= 1'b0;
            end

            // Sticky status
            if (!ctrl_en_q_i) begin
                ovf_q     <= 1'b0;
                partial_q <= 1'b0;
            end else begin
                if (drop) begin
                    ovf_q <= 1'b1;
                end
                if (flush && (bitcnt_q != 5'd0)) begin
                    partial_q <= 1'b1;
                end
            end
        end
    end

    assign wfg_axis_tvalid_o = tvalid_q;
    assign wfg_axis_tlast_o  = tlast_q;
    assign wfg_axis_tdata_o  = tdata_q;
    assign status_ovf_o      = ovf_q;
    assign status_partial_o  = partial_q;

endmodule

// File: tb/tb_wfg_record_spi.sv
// -----------------------------------------------------------------------------
// tb_wfg_record_spi
//
// Self-checking bench for wfg_record_spi. The bench acts as the SPI master,
// queues the words it transmits as expected AXIS beats, and a compare process
// checks every output handshake against that queue. Directed scenarios cover
// the basic modes, overflow, partial words, enable abort and reset; a random
// section sweeps modes, word sizes, bit order, CS polarity and tready.
// -----------------------------------------------------------------------------
module tb_wfg_record_spi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        sdi = 1'b0;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic [31:0] tdata;
    logic        en = 1'b1;
    logic        cpha = 1'b0;
    logic        cpol = 1'b0;
    logic        lsb = 1'b0;
    logic [1:0]  dff = 2'd0;
    logic        sspol = 1'b0;
    logic        ovf;
    logic        partial;

    always #5 clk = ~clk;

    wfg_record_spi #(.AXIS_DATA_WIDTH(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .wfg_record_spi_sclk_i (sclk),
        .wfg_record_spi_cs_ni  (cs),
        .wfg_record_spi_sdi_i  (sdi),
        .wfg_axis_tvalid_o     (tvalid),
        .wfg_axis_tready_i     (tready),
        .wfg_axis_tlast_o      (tlast),
        .wfg_axis_tdata_o      (tdata),
        .ctrl_en_q_i           (en),
        .cfg_cpha_q_i          (cpha),
        .cfg_cpol_q_i          (cpol),
        .cfg_lsbfirst_q_i      (lsb),
        .cfg_dff_q_i           (dff),
        .cfg_sspol_q_i         (sspol),
        .status_ovf_o          (ovf),
        .status_partial_o      (partial)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected beats: {tlast, tdata}
    logic [32:0] exp_q[$];
    int          beat_cnt = 0;
    logic [31:0] last_data = '0;
    logic        last_tlast = 1'b0;

    // Compare process: every handshake must match the head of the model queue
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data 0x%08h tlast %0b, expected no beat", tdata, tlast);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tdata, e[31:0]);
                    check("beat_tlast", {31'd0, tlast}, {31'd0, e[32]});
                end
                beat_cnt++;
                last_data  = tdata;
                last_tlast = tlast;
            end
        end
    end

    // tready driver: 0 = always ready, 1 = random (never low > 3 cycles), 2 = never ready
    int ready_mode = 0;
    initial begin
        int lows = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tready = 1'b1;
                2: tready = 1'b0;
                default: begin
                    if (lows >= 3 || $urandom_range(0, 3) != 0) begin
                        tready = 1'b1;
                        lows   = 0;
                    end else begin
                        tready = 1'b0;
                        lows++;
                    end
                end
            endcase
        end
    end

    // Global time bound
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time bound expired");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // SPI master (all pin changes on the falling edge of clk)
    // ------------------------------------------------------------------
    localparam int H = 4;   // sclk half-period in clk cycles

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_set(input logic act);
        cs = act ? sspol : ~sspol;
    endtask

    task automatic send_bit(input logic b);
        if (!cpha) begin
            sdi = b;
            clks(H);
            sclk = ~cpol;
            clks(H);
            sclk = cpol;
        end else begin
            sclk = ~cpol;
            sdi  = b;
            clks(H);
            sclk = cpol;
            clks(H);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int nb);
        for (int k = 0; k < nb; k++) begin
            send_bit(lsb ? w[k] : w[nb-1-k]);
        end
    endtask

    function automatic logic [31:0] mask_of(input int nb);
        return (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    endfunction

    task automatic set_mode(input logic p, input logic h, input logic l,
                            input logic [1:0] d, input logic s);
        cpol  = p;
        cpha  = h;
        lsb   = l;
        dff   = d;
        sspol = s;
        cs    = ~s;
        sclk  = p;
        clks(6);
    endtask

    logic [31:0] fw [4];

    // One CS frame of nw full words plus pbits trailing bits
    task automatic spi_frame(input int nw, input int pbits, input bit expect_out);
        int nb;
        nb = 8 * (int'(dff) + 1);
        cs_set(1'b1);
        clks(4);
        for (int i = 0; i < nw; i++) begin
            send_word(fw[i], nb);
            if (expect_out) begin
                exp_q.push_back({(i == nw - 1) ? 1'b1 : 1'b0, fw[i] & mask_of(nb)});
            end
        end
        for (int k = 0; k < pbits; k++) begin
            send_bit(1'($urandom_range(0, 1)));
        end
        clks(H);
        cs_set(1'b0);
        clks(12);
    endtask

    task automatic clear_flags();
        en = 1'b0;
        clks(2);
        en = 1'b1;
        clks(2);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int c0;
        int lat;
        int nw, pb, nb;

        // Reset state
        clks(3);
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tlast", {31'd0, tlast}, 32'd0);
        check("rst_flags", {30'd0, ovf, partial}, 32'd0);
        rst_n = 1'b1;
        clks(4);

        // 1: mode 0, MSB-first, 8 bits, 0xA5; beat within 4 clk of CS deassert
        set_mode(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        c0 = beat_cnt;
        cs_set(1'b1);
        clks(4);
        send_word(32'hA5, 8);
        exp_q.push_back({1'b1, 32'h0000_00A5});
        clks(H);
        cs_set(1'b0);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            clks(1);
            if (tvalid) begin
                lat = n;
                break;
            end
        end
        check("t1_latency_1to4", {31'd0, (lat >= 1 && lat <= 4) ? 1'b1 : 1'b0}, 32'd1);
        clks(12);
        check("t1_beats", beat_cnt - c0, 32'd1);
        check("t1_data", last_data, 32'h0000_00A5);
        check("t1_flags", {30'd0, ovf, partial}, 32'd0);

        // 2: mode 3, LSB-first, 32 bits, two words in one frame
        set_mode(1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
        c0 = beat_cnt;
        fw[0] = 32'h1234_5678;
        fw[1] = 32'hCAFE_BABE;
        spi_frame(2, 0, 1'b1);
        check("t2_beats", beat_cnt - c0, 32'd2);
        check("t2_last", last_data, 32'hCAFE_BABE);

        // 3: all four modes, 16 bits, one word per frame
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b0, 2'd1, 1'b0);
            fw[0] = 32'h0001;
            spi_frame(1, 0, 1'b1);
            check("t3_w0001", last_data, 32'h0000_0001);
            fw[0] = 32'h8000;
            spi_frame(1, 0, 1'b1);
            check("t3_w8000", last_data, 32'h0000_8000);
            check("t3_tlast", {31'd0, last_tlast}, 32'd1);
        end

        // 4: tready low across three words. Word 1 sits in the output slice,
        // word 2 is pushed against a full slice and dropped, word 3 stays
        // staged and leaves at flush.
        set_mode(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        ready_mode = 2;
        clks(3);
        cs_set(1'b1);
        clks(4);
        send_word(32'h81, 8);
        send_word(32'h42, 8);
        send_word(32'h24, 8);
        clks(2);
        check("t4_held_valid", {31'd0, tvalid}, 32'd1);
        check("t4_held_data", tdata, 32'h0000_0081);
        check("t4_ovf", {31'd0, ovf}, 32'd1);
        exp_q.push_back({1'b0, 32'h81});
        exp_q.push_back({1'b1, 32'h24});
        ready_mode = 0;
        clks(4);
        cs_set(1'b0);
        clks(12);
        check("t4_last", last_data, 32'h0000_0024);
        clear_flags();
        check("t4_ovf_cleared", {31'd0, ovf}, 32'd0);

        // 5: one full word 0x3C then 5 stray bits
        c0 = beat_cnt;
        fw[0] = 32'h3C;
        spi_frame(1, 5, 1'b1);
        check("t5_beats", beat_cnt - c0, 32'd1);
        check("t5_data", last_data, 32'h0000_003C);
        check("t5_partial", {31'd0, partial}, 32'd1);
        check("t5_ovf", {31'd0, ovf}, 32'd0);
        en = 1'b0;
        clks(2);
        check("t5_partial_cleared", {31'd0, partial}, 32'd0);
        en = 1'b1;
        clks(2);

        // Enable dropped mid-frame after one staged word: nothing is emitted
        c0 = beat_cnt;
        fw[0] = 32'hC3;
        fw[1] = 32'h99;
        fork
            spi_frame(2, 0, 1'b0);
            begin
                clks(4 + 8 * 2 * H + 12);
                en = 1'b0;
            end
        join
        en = 1'b1;
        clks(4);
        check("abort_no_beats", beat_cnt - c0, 32'd0);
        check("abort_flags", {30'd0, ovf, partial}, 32'd0);

        // 6: reset mid-word while a beat is held, then a clean frame
        ready_mode = 2;
        clks(3);
        fw[0] = 32'h77;
        spi_frame(1, 0, 1'b0);
        check("t6_held_before_rst", {31'd0, tvalid}, 32'd1);
        cs_set(1'b1);
        clks(4);
        for (int k = 0; k < 4; k++) begin
            send_bit(1'b1);
        end
        rst_n = 1'b0;
        clks(1);
        check("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("t6_rst_tdata", tdata, 32'd0);
        check("t6_rst_tlast", {31'd0, tlast}, 32'd0);
        check("t6_rst_flags", {30'd0, ovf, partial}, 32'd0);
        cs_set(1'b0);
        ready_mode = 0;
        clks(4);
        rst_n = 1'b1;
        clks(4);
        c0 = beat_cnt;
        fw[0] = 32'h5A;
        spi_frame(1, 0, 1'b1);
        check("t6_beats", beat_cnt - c0, 32'd1);
        check("t6_data", last_data, 32'h0000_005A);

        // Random frames
        ready_mode = 1;
        for (int f = 0; f < 20; f++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            nb = 8 * (int'(dff) + 1);
            nw = $urandom_range(1, 3);
            pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < nw; i++) begin
                fw[i] = $urandom() & mask_of(nb);
            end
            c0 = beat_cnt;
            spi_frame(nw, pb, 1'b1);
            check("rnd_beats", beat_cnt - c0, nw);
            check("rnd_drained", exp_q.size(), 32'd0);
            check("rnd_ovf", {31'd0, ovf}, 32'd0);
            check("rnd_partial", {31'd0, partial}, {31'd0, (pb != 0) ? 1'b1 : 1'b0});
            clear_flags();
        end
        ready_mode = 0;
        clks(10);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
